latch_bank_ctrl: RTL and testbench

LATCH_BANK_CTRL -- requirements
Module: latch_bank_ctrl

---
 rtl/latch_bank_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_latch_bank_ctrl.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// latch_bank_ctrl
//
// Write controller for a bank of NWORDS level-sensitive latches that share
// one data bus (WD) and have one enable line each (LE). Two requesters
// compete for the bank. Each write goes through three timed phases:
//   SETUP : WD is driven and LE stays low       (SETUP_CYC cycles)
//   PULSE : LE[addr] is high                    (PULSE_CYC cycles)
//   HOLD  : LE is low again and WD is unchanged (HOLD_CYC cycles)
// After HOLD the winner gets a one-cycle ACK and the controller goes back
// to IDLE.
//
// Optional feature macro: LATCH_BANK_CTRL_RR_EN
//   defined   -> round-robin arbitration with a one-bit pointer
//   undefined -> fixed priority, REQ0 wins every tie (no pointer)
//
// Parameters
//   NWORDS    : number of latch words (power of two, 2..16)
//   WIDTH     : data width of each word
//   SETUP_CYC : cycles from data driven to enable high (1..15)
//   PULSE_CYC : cycles the enable is high (1..15)
//   HOLD_CYC  : cycles data is held after the enable falls (1..15)
//
// Ports
//   CLK          in   clock; all state changes on its rising edge
//   R            in   asynchronous active-low reset
//   REQ0/REQ1    in   write request from requester 0 / 1
//   ADDR0/ADDR1  in   target word of each requester
//   DATA0/DATA1  in   write data of each requester
//   ACK0/ACK1    out  one-cycle completion pulse to each requester
//   LE           out  latch enables (at most one bit high)
//   WD           out  data to the latch D pins
//   BUSY         out  high whenever the controller is not IDLE
//
// Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module latch_bank_ctrl #(
   parameter int NWORDS    = 4,
   parameter int WIDTH     = 8,
   parameter int SETUP_CYC = 1,
   parameter int PULSE_CYC = 2,
   parameter int HOLD_CYC  = 1
) (
   input  logic                      CLK,
   input  logic                      R,
   input  logic                      REQ0,
   input  logic                      REQ1,
   input  logic [$clog2(NWORDS)-1:0] ADDR0,
   input  logic [$clog2(NWORDS)-1:0] ADDR1,
   input  logic [WIDTH-1:0]          DATA0,
   input  logic [WIDTH-1:0]          DATA1,
   output logic                      ACK0,
   output logic                      ACK1,
   output logic [NWORDS-1:0]         LE,
   output logic [WIDTH-1:0]          WD,
   output logic                      BUSY
);

   localparam int AW = $clog2(NWORDS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_PULSE = 2'd2;
   localparam logic [1:0] ST_HOLD  = 2'd3;

   // The phase counter is loaded with (length - 1) on entry to a phase and
   // the phase ends on the edge where it is seen at zero, so a phase of
   // length N occupies exactly N cycles.
   localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
   localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q,   cnt_d;
   logic [AW-1:0]     word_q,  word_d;
   logic              owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
   logic [NWORDS-1:0] le_q,    le_d;
   logic [WIDTH-1:0]  wd_q,    wd_d;
   logic              ack0_q,  ack0_d;
   logic              ack1_q,  ack1_d;
   logic              busy_q,  busy_d;

   // ---------------------------------------------------------------------
   // Word address decode
   // ---------------------------------------------------------------------
   logic [NWORDS-1:0] word_onehot;

   genvar gi;
   generate
      for (gi = 0; gi < NWORDS; gi++) begin : g_dec
         assign word_onehot[gi] = (word_q == AW'(gi));
      end
   endgenerate

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   // A requester whose ACK is high this cycle is still holding REQ (it only
   // drops it the cycle after ACK), so it is masked to avoid a second accept
   // of the same write.
   logic elig0, elig1;
   logic grant0, grant1;
   logic accept;

   assign elig0 = REQ0 && !ack0_q;
   assign elig1 = REQ1 && !ack1_q;

`ifdef LATCH_BANK_CTRL_RR_EN
   // rr_ptr_q names the requester that wins the next tie.
   logic rr_ptr_q, rr_ptr_d;

   assign grant1 = elig1 && (!elig0 || rr_ptr_q);

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = ~rr_ptr_q;
      end
   end

   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         rr_ptr_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`else
   assign grant1 = elig1 && !elig0;
`endif

   assign grant0 = elig0 && !grant1;
   assign accept = (state_q == ST_IDLE) && (grant0 || grant1);

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      owner_d = owner_q;
      le_d    = le_q;
      wd_d    = wd_q;
      ack0_d  = 1'b0;
      ack1_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // ADDR/DATA are captured only here; WD then stays frozen
            // until the controller is back in IDLE.
            if (accept) begin
               word_d  = grant1 ? ADDR1 : ADDR0;
               wd_d    = grant1 ? DATA1 : DATA0;
               owner_d = grant1;
               cnt_d   = SETUP_LD;
               state_d = ST_SETUP;
            end
         end

         ST_SETUP: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
               le_d    = word_onehot;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_PULSE: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_HOLD;
               cnt_d   = HOLD_LD;
               le_d    = '0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_HOLD: begin
            if (cnt_q == 4'd0) begin
               state_d = ST_IDLE;
               cnt_d   = 4'd0;
               ack0_d  = !owner_q;
               ack1_d  = owner_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
            le_d    = '0;
         end
      endcase

      // BUSY is registered from the next state so it lines up with the
      // state register instead of lagging it by one cycle.
      busy_d = (state_d != ST_IDLE);
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // Reset is asynchronous so LE drops immediately even in the middle of
   // a pulse; a write cut short this way is never acknowledged.
   always_ff @(posedge CLK or negedge R) begin
      if (!R) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         word_q  <= '0;
         owner_q <= 1'b0;
         le_q    <= '0;
         wd_q    <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
         owner_q <= owner_d;
         le_q    <= le_d;
         wd_q    <= wd_d;
         ack0_q  <= ack0_d;
         ack1_q  <= ack1_d;
         busy_q  <= busy_d;
      end
   end

   assign LE   = le_q;
   assign WD   = wd_q;
   assign ACK0 = ack0_q;
   assign ACK1 = ack1_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_latch_bank_ctrl
//
// Directed bench for latch_bank_ctrl. One instance uses the default timing
// (1/2/1), a second one uses SETUP=3, PULSE=15, HOLD=2. Edge numbers in the
// comments count from the accepting edge (edge 0). Outputs are sampled 1 ns
// after each rising edge and inputs are changed at that same point.
// -----------------------------------------------------------------------------
module tb_latch_bank_ctrl;

   logic       CLK;
   logic       R;
   logic       req0, req1;
   logic [1:0] addr0, addr1;
   logic [7:0] data0, data1;
   logic       ack0, ack1;
   logic [3:0] le;
   logic [7:0] wd;
   logic       busy;

   logic       l_req0, l_req1;
   logic [1:0] l_addr0, l_addr1;
   logic [7:0] l_data0, l_data1;
   logic       l_ack0, l_ack1;
   logic [3:0] l_le;
   logic [7:0] l_wd;
   logic       l_busy;

   int tests_run;
   int tests_failed;

   latch_bank_ctrl u_dut (
      .CLK   (CLK),
      .R     (R),
      .REQ0  (req0),
      .REQ1  (req1),
      .ADDR0 (addr0),
      .ADDR1 (addr1),
      .DATA0 (data0),
      .DATA1 (data1),
      .ACK0  (ack0),
      .ACK1  (ack1),
      .LE    (le),
      .WD    (wd),
      .BUSY  (busy)
   );

   latch_bank_ctrl #(
      .NWORDS    (4),
      .WIDTH     (8),
      .SETUP_CYC (3),
      .PULSE_CYC (15),
      .HOLD_CYC  (2)
   ) u_dut_long (
      .CLK   (CLK),
      .R     (R),
      .REQ0  (l_req0),
      .REQ1  (l_req1),
      .ADDR0 (l_addr0),
      .ADDR1 (l_addr1),
      .DATA0 (l_data0),
      .DATA1 (l_data1),
      .ACK0  (l_ack0),
      .ACK1  (l_ack1),
      .LE    (l_le),
      .WD    (l_wd),
      .BUSY  (l_busy)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      R = 1'b0;
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'hFF;   // must be ignored in reset
      tick();
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_busy_req: got %b expected 0", busy);
      end
      req0 = 1'b0;
      tick();
      tests_run++;
      if (le !== 4'b0000) begin
         tests_failed++; $display("FAIL reset_le: got %b expected 0000", le);
      end
      tests_run++;
      if (wd !== 8'h00) begin
         tests_failed++; $display("FAIL reset_wd: got %h expected 00", wd);
      end
      tests_run++;
      if ({ack1, ack0} !== 2'b00) begin
         tests_failed++; $display("FAIL reset_ack: got %b expected 00", {ack1, ack0});
      end
      R = 1'b1;
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
      end
      $display("[TB] reset released");
   endtask

   // ------------------------------------------------------------------
   task automatic test_basic();
      req0 = 1'b1; addr0 = 2'd2; data0 = 8'hA5;
      tick();   // edge 0
      tests_run++;
      if (wd !== 8'hA5 || busy !== 1'b1 || le !== 4'b0000) begin
         tests_failed++;
         $display("FAIL basic_e0: got wd=%h busy=%b le=%b expected a5 1 0000", wd, busy, le);
      end
      tick();   // edge 1
      tests_run++;
      if (le !== 4'b0100) begin
         tests_failed++; $display("FAIL basic_le_e1: got %b expected 0100", le);
      end
      tick();   // edge 2
      tests_run++;
      if (le !== 4'b0100) begin
         tests_failed++; $display("FAIL basic_le_e2: got %b expected 0100", le);
      end
      tick();   // edge 3
      tests_run++;
      if (le !== 4'b0000 || busy !== 1'b1 || ack0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL basic_e3: got le=%b busy=%b ack0=%b expected 0000 1 0", le, busy, ack0);
      end
      tick();   // edge 4
      tests_run++;
      if (ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b0 || wd !== 8'hA5) begin
         tests_failed++;
         $display("FAIL basic_e4: got ack0=%b ack1=%b busy=%b wd=%h expected 1 0 0 a5",
                  ack0, ack1, busy, wd);
      end
      tick();   // edge 5
      req0 = 1'b0;
      tests_run++;
      if (ack0 !== 1'b0) begin
         tests_failed++; $display("FAIL basic_ack_width: got %b expected 0", ack0);
      end
      $display("[TB] txn basic: req0 addr=2 data=a5 done");
   endtask

   // ------------------------------------------------------------------
   task automatic test_no_dup();
      int extra_le;
      int extra_busy;
      extra_le   = 0;
      extra_busy = 0;
      req0 = 1'b1; addr0 = 2'd3; data0 = 8'h0F;
      for (int e = 0; e <= 4; e++) tick();
      tests_run++;
      if (ack0 !== 1'b1) begin
         tests_failed++; $display("FAIL nodup_ack: got %b expected 1", ack0);
      end
      tick();   // edge 5: REQ0 still high while ACK0 high
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL nodup_busy_e5: got %b expected 0", busy);
      end
      req0 = 1'b0;
      for (int e = 6; e <= 9; e++) begin
         tick();
         if (le !== 4'b0000) extra_le++;
         if (busy !== 1'b0)  extra_busy++;
      end
      tests_run++;
      if (extra_le != 0 || extra_busy != 0) begin
         tests_failed++;
         $display("FAIL nodup_second: got le_cycles=%0d busy_cycles=%0d expected 0 0",
                  extra_le, extra_busy);
      end
      $display("[TB] txn no_dup: req0 addr=3 data=0f done");
   endtask

   // ------------------------------------------------------------------
   task automatic test_data_hold();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'hA5;
      tick();   // edge 0
      tick();   // edge 1, PULSE
      data0 = 8'h3C; addr0 = 2'd3;
      tick();   // edge 2
      tests_run++;
      if (wd !== 8'hA5 || le !== 4'b0010) begin
         tests_failed++;
         $display("FAIL hold_e2: got wd=%h le=%b expected a5 0010", wd, le);
      end
      tick();   // edge 3, HOLD
      tests_run++;
      if (wd !== 8'hA5 || le !== 4'b0000) begin
         tests_failed++;
         $display("FAIL hold_e3: got wd=%h le=%b expected a5 0000", wd, le);
      end
      tick();   // edge 4
      tests_run++;
      if (wd !== 8'hA5 || ack0 !== 1'b1) begin
         tests_failed++;
         $display("FAIL hold_e4: got wd=%h ack0=%b expected a5 1", wd, ack0);
      end
      tick();   // edge 5
      req0 = 1'b0;
      $display("[TB] txn data_hold: req0 addr=1 data=a5 (changed to 3c mid-pulse) done");
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset_abort();
      int acks;
      int busys;
      acks  = 0;
      busys = 0;
      req0 = 1'b1; addr0 = 2'd3; data0 = 8'h5A;
      tick();   // edge 0
      tick();   // edge 1
      tests_run++;
      if (le !== 4'b1000) begin
         tests_failed++; $display("FAIL abort_le_pulse: got %b expected 1000", le);
      end
      tick();   // edge 2, still PULSE
      #3;
      R = 1'b0;
      #1;
      tests_run++;
      if (le !== 4'b0000 || wd !== 8'h00 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL abort_async: got le=%b wd=%h busy=%b expected 0000 00 0", le, wd, busy);
      end
      req0 = 1'b0;
      tick();
      R = 1'b1;
      for (int e = 0; e < 8; e++) begin
         tick();
         if (ack0 !== 1'b0 || ack1 !== 1'b0) acks++;
         if (busy !== 1'b0) busys++;
      end
      tests_run++;
      if (acks != 0 || busys != 0) begin
         tests_failed++;
         $display("FAIL abort_no_ack: got ack_cycles=%0d busy_cycles=%0d expected 0 0", acks, busys);
      end
      $display("[TB] txn reset_abort: req0 addr=3 data=5a aborted");
   endtask

   // ------------------------------------------------------------------
   // Tie from a freshly reset controller: requester 0 wins in either
   // arbitration mode, requester 1 waits and is served next.
   task automatic test_tie();
      req0 = 1'b1; addr0 = 2'd1; data0 = 8'h11;
      req1 = 1'b1; addr1 = 2'd3; data1 = 8'h22;
      tick();   // edge 0
      tests_run++;
      if (wd !== 8'h11) begin
         tests_failed++; $display("FAIL tie_winner_wd: got %h expected 11", wd);
      end
      tick();   // edge 1
      tests_run++;
      if (le !== 4'b0010) begin
         tests_failed++; $display("FAIL tie_winner_le: got %b expected 0010", le);
      end
      tick(); tick(); tick();   // edge 4
      tests_run++;
      if ({ack1, ack0} !== 2'b01) begin
         tests_failed++; $display("FAIL tie_ack_first: got %b expected 01", {ack1, ack0});
      end
      tick();   // edge 5: requester 1 accepted
      req0 = 1'b0;
      tests_run++;
      if (wd !== 8'h22 || busy !== 1'b1 || ack0 !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_loser_accept: got wd=%h busy=%b ack0=%b expected 22 1 0", wd, busy, ack0);
      end
      tick();   // edge 6
      tests_run++;
      if (le !== 4'b1000) begin
         tests_failed++; $display("FAIL tie_loser_le: got %b expected 1000", le);
      end
      tick(); tick(); tick();   // edge 9
      tests_run++;
      if ({ack1, ack0} !== 2'b10) begin
         tests_failed++; $display("FAIL tie_ack_second: got %b expected 10", {ack1, ack0});
      end
      tick();   // edge 10
      req1 = 1'b0;
      tests_run++;
      if (busy !== 1'b0 || ack1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL tie_end: got busy=%b ack1=%b expected 0 0", busy, ack1);
      end
      $display("[TB] txn tie: req0 addr=1 data=11 then req1 addr=3 data=22 done");
   endtask

   // ------------------------------------------------------------------
   // One write from requester 0, then a tie. Fixed priority: requester 0
   // wins again. Round-robin: the pointer now names requester 1.
   task automatic test_arb_priority();
      logic [7:0] exp_wd_a, exp_wd_b;
      logic [3:0] exp_le_a, exp_le_b;
      logic [1:0] exp_ack_a, exp_ack_b;
      logic       first_is1;
`ifdef LATCH_BANK_CTRL_RR_EN
      first_is1 = 1'b1;
      exp_wd_a  = 8'h20; exp_le_a = 4'b0100; exp_ack_a = 2'b10;
      exp_wd_b  = 8'h10; exp_le_b = 4'b0001; exp_ack_b = 2'b01;
`else
      first_is1 = 1'b0;
      exp_wd_a  = 8'h10; exp_le_a = 4'b0001; exp_ack_a = 2'b01;
      exp_wd_b  = 8'h20; exp_le_b = 4'b0100; exp_ack_b = 2'b10;
`endif
      req0 = 1'b1; addr0 = 2'd0; data0 = 8'h01;
      for (int e = 0; e <= 5; e++) tick();
      req0 = 1'b0;
      tick();
      $display("[TB] txn arb_pre: req0 addr=0 data=01 done");

      req0 = 1'b1; addr0 = 2'd0; data0 = 8'h10;
      req1 = 1'b1; addr1 = 2'd2; data1 = 8'h20;
      tick();   // edge 0
      tests_run++;
      if (wd !== exp_wd_a) begin
         tests_failed++; $display("FAIL arb_first_wd: got %h expected %h", wd, exp_wd_a);
      end
      tick();   // edge 1
      tests_run++;
      if (le !== exp_le_a) begin
         tests_failed++; $display("FAIL arb_first_le: got %b expected %b", le, exp_le_a);
      end
      tick(); tick(); tick();   // edge 4
      tests_run++;
      if ({ack1, ack0} !== exp_ack_a) begin
         tests_failed++; $display("FAIL arb_first_ack: got %b expected %b", {ack1, ack0}, exp_ack_a);
      end
      tick();   // edge 5
      if (first_is1) req1 = 1'b0; else req0 = 1'b0;
      tests_run++;
      if (wd !== exp_wd_b) begin
         tests_failed++; $display("FAIL arb_second_wd: got %h expected %h", wd, exp_wd_b);
      end
      tick();   // edge 6
      tests_run++;
      if (le !== exp_le_b) begin
         tests_failed++; $display("FAIL arb_second_le: got %b expected %b", le, exp_le_b);
      end
      tick(); tick(); tick();   // edge 9
      tests_run++;
      if ({ack1, ack0} !== exp_ack_b) begin
         tests_failed++; $display("FAIL arb_second_ack: got %b expected %b", {ack1, ack0}, exp_ack_b);
      end
      tick();   // edge 10
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++; $display("FAIL arb_end_busy: got %b expected 0", busy);
      end
      $display("[TB] txn arb: tie req0 data=10 / req1 data=20 done");
   endtask

   // ------------------------------------------------------------------
   task automatic test_long_timing();
      int le_cnt, first_le, last_le, ack_edge, ack_cnt, le_bad;
      le_cnt = 0; first_le = -1; last_le = -1; ack_edge = -1; ack_cnt = 0; le_bad = 0;
      l_req0 = 1'b1; l_addr0 = 2'd1; l_data0 = 8'h77;
      tick();   // edge 0
      for (int e = 1; e <= 24; e++) begin
         tick();
         if (l_le !== 4'b0000) begin
            le_cnt++;
            if (first_le < 0) first_le = e;
            last_le = e;
            if (l_le !== 4'b0010) le_bad++;
         end
         if (l_ack0 === 1'b1) begin
            ack_cnt++;
            if (ack_edge < 0) ack_edge = e;
         end
         if (l_ack1 !== 1'b0) le_bad++;
         if (e == 21) l_req0 = 1'b0;
      end
      tests_run++;
      if (le_cnt != 15 || first_le != 3 || last_le != 17 || le_bad != 0) begin
         tests_failed++;
         $display("FAIL long_le: got cycles=%0d first=%0d last=%0d bad=%0d expected 15 3 17 0",
                  le_cnt, first_le, last_le, le_bad);
      end
      tests_run++;
      if (ack_edge != 20 || ack_cnt != 1) begin
         tests_failed++;
         $display("FAIL long_ack: got edge=%0d count=%0d expected 20 1", ack_edge, ack_cnt);
      end
      tests_run++;
      if (l_wd !== 8'h77 || l_busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL long_end: got wd=%h busy=%b expected 77 0", l_wd, l_busy);
      end
      $display("[TB] txn long: req0 addr=1 data=77 with 3/15/2 timing done");
   endtask

   // ------------------------------------------------------------------
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      R = 1'b0;
      req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
      l_req0 = 1'b0; l_req1 = 1'b0; l_addr0 = '0; l_addr1 = '0; l_data0 = '0; l_data1 = '0;

      test_reset();
      test_basic();
      test_no_dup();
      test_data_hold();
      test_reset_abort();
      test_tie();
      test_arb_priority();
      test_long_timing();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
